// File: rtl/locker_entry_ctrl_if.sv
// Button, code and indicator bundle between the locker pins and the entry controller.
interface locker_entry_ctrl_if;
  logic        BTNA;
  logic        BTNB;
  logic        BTNC;
  logic        BTND;
  logic        BTNE;
  logic        BTNF;
  logic [17:0] CODE;
  logic        SUCESS_COMB_LED;
  logic        WRONG_COMB_LED;
  logic        LOCKED_OUT;
  logic [2:0]  ENTRY_CNT;
  logic [17:0] ENTERED;
  logic        PRESS_STB;

  // Controller side: consumes buttons and code, drives indicators.
  modport slave (
    input  BTNA, BTNB, BTNC, BTND, BTNE, BTNF, CODE,
    output SUCESS_COMB_LED, WRONG_COMB_LED, LOCKED_OUT, ENTRY_CNT, ENTERED, PRESS_STB
  );

  // Board/stimulus side.
  modport master (
    output BTNA, BTNB, BTNC, BTND, BTNE, BTNF, CODE,
    input  SUCESS_COMB_LED, WRONG_COMB_LED, LOCKED_OUT, ENTRY_CNT, ENTERED, PRESS_STB
  );
endinterface

// File: rtl/locker_entry_ctrl.sv
// Six-button combination locker entry controller: synchronizes and arbitrates
// button presses, collects a six-digit combination, checks it and enforces lockout.
module locker_entry_ctrl #(
  parameter int unsigned CODE_LEN       = 6,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned WRONG_HOLD     = 50,
  parameter int unsigned LOCKOUT_CYCLES = 200
) (
  input logic              CLK,
  input logic              RST,
  locker_entry_ctrl_if.slave bus
);

  localparam int unsigned TimerMax = (WRONG_HOLD > LOCKOUT_CYCLES) ? WRONG_HOLD : LOCKOUT_CYCLES;
  localparam int unsigned TimerW   = $clog2(TimerMax + 1);

  typedef enum logic [2:0] {
    StEntry,
    StCheck,
    StSuccess,
    StWrong,
    StLockout
  } state_e;

  logic [5:0] btn;
  logic [5:0] sync1_q, sync2_q, prev_q, rise_q;
  logic [1:0] warm_q;

  logic       press_vld;
  logic [2:0] digit;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [17:0]       entered_q, entered_d;
  logic              mismatch_q, mismatch_d;
  logic [2:0]        tries_q, tries_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              accept;

  logic press_stb_q, success_q, wrong_q, locked_q;

  assign btn = {bus.BTNF, bus.BTNE, bus.BTND, bus.BTNC, bus.BTNB, bus.BTNA};

  // Two-flop synchronizer and registered rising-edge detect. Edges are masked for the
  // first three edges after reset so a button held through reset release is not a press.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
      warm_q  <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= (warm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
      if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
    end
  end

  // Lowest letter wins when several edges coincide; the others are dropped.
  always_comb begin
    press_vld = |rise_q;
    digit     = '0;
    for (int i = 5; i >= 0; i--) begin
      if (rise_q[i]) digit = 3'(i);
    end
  end

  // Next-state logic for the entry/check/result sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    entered_d  = entered_q;
    mismatch_d = mismatch_q;
    tries_d    = tries_q;
    timer_d    = timer_q;
    accept     = 1'b0;
    unique case (state_q)
      StEntry: begin
        if (cnt_q == 3'(CODE_LEN)) begin
          state_d = StCheck;
        end else if (press_vld) begin
          accept = 1'b1;
          for (int i = 0; i < 6; i++) begin
            if (cnt_q == 3'(i)) begin
              entered_d[3*i +: 3] = digit;
              if (bus.CODE[3*i +: 3] != digit) mismatch_d = 1'b1;
            end
          end
          cnt_d = cnt_q + 3'd1;
        end
      end
      StCheck: begin
        if (!mismatch_q) begin
          state_d = StSuccess;
          tries_d = '0;
        end else begin
          tries_d    = tries_q + 3'd1;
          // Clear the attempt now so the count reads 0 throughout WRONG/LOCKOUT.
          cnt_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
          if (tries_d == 3'(MAX_TRIES)) begin
            state_d = StLockout;
            timer_d = TimerW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = StWrong;
            timer_d = TimerW'(WRONG_HOLD - 1);
          end
        end
      end
      StSuccess: begin
      end
      StWrong: begin
        if (timer_q == '0) begin
          state_d    = StEntry;
          cnt_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d    = StEntry;
          cnt_d      = '0;
          entered_d  = '0;
          mismatch_d = 1'b0;
          tries_d    = '0;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: begin
        state_d = StEntry;
      end
    endcase
  end

  // State, attempt registers and registered indicator outputs.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StEntry;
      cnt_q       <= '0;
      entered_q   <= '0;
      mismatch_q  <= 1'b0;
      tries_q     <= '0;
      timer_q     <= '0;
      press_stb_q <= 1'b0;
      success_q   <= 1'b0;
      wrong_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      entered_q   <= entered_d;
      mismatch_q  <= mismatch_d;
      tries_q     <= tries_d;
      timer_q     <= timer_d;
      press_stb_q <= accept;
      success_q   <= (state_d == StSuccess);
      wrong_q     <= (state_d == StWrong) || (state_d == StLockout);
      locked_q    <= (state_d == StLockout);
    end
  end

  assign bus.SUCESS_COMB_LED = success_q;
  assign bus.WRONG_COMB_LED  = wrong_q;
  assign bus.LOCKED_OUT      = locked_q;
  assign bus.ENTRY_CNT       = cnt_q;
  assign bus.ENTERED         = entered_q;
  assign bus.PRESS_STB       = press_stb_q;

endmodule
